// File: rtl/apb_ucpd_tx_sched.sv
// apb_ucpd_tx_sched: UCPD transmit scheduler, arbitrates send/hard-reset requests and
// sequences the clock-generator controls through transition window, BMC and interframe gap.
// Optional transition-window watchdog with ERR state when UCPD_TX_WDOG_EN is defined.
module apb_ucpd_tx_sched #(
    parameter int WDOG_W = 12
) (
    input  logic       ic_clk,
    input  logic       ic_rst,
    input  logic       ucpd_en,
    input  logic       txsend_req,
    input  logic       txhrst_req,
    input  logic [1:0] txmode,
    input  logic       rx_busy,
    input  logic       transwin_en,
    input  logic       ifrgap_en,
    input  logic       hbit_clk_red,
    input  logic       tx_eop_cmplt,
    input  logic       tx_sop_rst_cmplt,
    output logic       transmit_en,
    output logic       bmc_en,
    output logic       wait_en,
    output logic       tx_start,
    output logic [1:0] tx_kind,
    output logic       tx_abort,
    output logic       txmsgsent,
    output logic       hrstsent,
    output logic       txmsgdisc,
    output logic       txmsgabt,
    output logic       tx_busy
);

`ifdef UCPD_TX_WDOG_EN
    typedef enum logic [2:0] {IDLE, START, BMC, GAP, ERR} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, BMC, GAP} state_t;
`endif

    if (WDOG_W < 2) begin : g_wdog_w_chk
        $error("apb_ucpd_tx_sched: WDOG_W must be at least 2");
    end

    state_t     state, state_nx;
    logic       msg_pend, hrst_pend, msg_clr, hrst_clr;
    logic [1:0] msg_kind, kind_nx;
    logic       aborted, aborted_nx;
    logic       done;
    logic       start_nx, abort_nx, sent_nx, hsent_nx, disc_nx, abt_nx;

`ifdef UCPD_TX_WDOG_EN
    localparam logic [WDOG_W-1:0] WDOG_LAST = {{(WDOG_W-1){1'b1}}, 1'b0};
    logic [WDOG_W-1:0] wdog;

    // Watchdog counts START cycles and is zero everywhere else, so each START entry begins at zero
    always_ff @(posedge ic_clk or posedge ic_rst) begin
        if (ic_rst)
            wdog <= '0;
        else
            wdog <= (state == START) ? wdog + 1'b1 : '0;
    end
`endif

    // Next-state and next-pulse decode; completion is checked before the abort condition
    always_comb begin
        state_nx   = state;
        msg_clr    = 1'b0;
        hrst_clr   = 1'b0;
        kind_nx    = tx_kind;
        aborted_nx = aborted;
        start_nx   = 1'b0;
        abort_nx   = 1'b0;
        sent_nx    = 1'b0;
        hsent_nx   = 1'b0;
        disc_nx    = 1'b0;
        abt_nx     = 1'b0;
        done       = tx_kind[0] ? tx_sop_rst_cmplt : tx_eop_cmplt;
        if (!ucpd_en) begin
            state_nx = IDLE;
            abort_nx = (state == BMC);
        end else begin
            case (state)
                IDLE: begin
                    if (hrst_pend) begin
                        hrst_clr   = 1'b1;
                        kind_nx    = 2'd3;
                        aborted_nx = 1'b0;
                        state_nx   = START;
                    end else if (msg_pend) begin
                        msg_clr = 1'b1;
                        if (rx_busy) begin
                            disc_nx = 1'b1;
                        end else begin
                            kind_nx    = msg_kind;
                            aborted_nx = 1'b0;
                            state_nx   = START;
                        end
                    end
                end
                START: begin
                    if (transwin_en) begin
                        start_nx = 1'b1;
                        state_nx = BMC;
                    end
`ifdef UCPD_TX_WDOG_EN
                    else if (wdog == WDOG_LAST) begin
                        disc_nx  = 1'b1;
                        state_nx = ERR;
                    end
`endif
                end
                BMC: begin
                    if (done) begin
                        state_nx = GAP;
                    end else if (hrst_pend && tx_kind != 2'd3 && hbit_clk_red) begin
                        abort_nx   = 1'b1;
                        abt_nx     = 1'b1;
                        aborted_nx = 1'b1;
                        state_nx   = GAP;
                    end
                end
                GAP: begin
                    if (ifrgap_en) begin
                        state_nx = IDLE;
                        hsent_nx = (tx_kind == 2'd3);
                        sent_nx  = (tx_kind != 2'd3) && !aborted;
                    end
                end
`ifdef UCPD_TX_WDOG_EN
                ERR: state_nx = IDLE;
`endif
                default: state_nx = IDLE;
            endcase
        end
    end

    // Pending request flags; a request that finds its flag already set is dropped
    always_ff @(posedge ic_clk or posedge ic_rst) begin
        if (ic_rst) begin
            msg_pend  <= 1'b0;
            msg_kind  <= 2'd0;
            hrst_pend <= 1'b0;
        end else begin
            msg_pend  <= !ucpd_en ? 1'b0 : msg_pend ? !msg_clr : txsend_req;
            hrst_pend <= !ucpd_en ? 1'b0 : hrst_pend ? !hrst_clr : txhrst_req;
            if (ucpd_en && !msg_pend && txsend_req)
                msg_kind <= (txmode == 2'd3) ? 2'd0 : txmode;
        end
    end

    // State, frame kind and all registered outputs
    always_ff @(posedge ic_clk or posedge ic_rst) begin
        if (ic_rst) begin
            state       <= IDLE;
            tx_kind     <= 2'd0;
            aborted     <= 1'b0;
            transmit_en <= 1'b0;
            bmc_en      <= 1'b0;
            wait_en     <= 1'b0;
            tx_busy     <= 1'b0;
            tx_start    <= 1'b0;
            tx_abort    <= 1'b0;
            txmsgsent   <= 1'b0;
            hrstsent    <= 1'b0;
            txmsgdisc   <= 1'b0;
            txmsgabt    <= 1'b0;
        end else begin
            state       <= state_nx;
            tx_kind     <= kind_nx;
            aborted     <= aborted_nx;
            transmit_en <= (state_nx == START) || (state_nx == BMC) || (state_nx == GAP);
            bmc_en      <= (state_nx == BMC);
            wait_en     <= (state_nx == GAP);
            tx_busy     <= (state_nx != IDLE);
            tx_start    <= start_nx;
            tx_abort    <= abort_nx;
            txmsgsent   <= sent_nx;
            hrstsent    <= hsent_nx;
            txmsgdisc   <= disc_nx;
            txmsgabt    <= abt_nx;
        end
    end

endmodule

// File: tb/tb_apb_ucpd_tx_sched.sv
// tb_apb_ucpd_tx_sched: directed self-checking bench for the UCPD transmit scheduler.
module tb_apb_ucpd_tx_sched;

    logic       ic_clk = 1'b0;
    logic       ic_rst, ucpd_en, txsend_req, txhrst_req, rx_busy;
    logic [1:0] txmode;
    logic       transwin_en, ifrgap_en, hbit_clk_red, tx_eop_cmplt, tx_sop_rst_cmplt;
    logic       transmit_en, bmc_en, wait_en, tx_start, tx_abort;
    logic       txmsgsent, hrstsent, txmsgdisc, txmsgabt, tx_busy;
    logic [1:0] tx_kind;
    logic [2:0] ctl;
    logic [11:0] outs;

    int checks = 0;
    int failures = 0;
    int n_start = 0, n_sent = 0, n_hsent = 0, n_disc = 0, n_abt = 0, n_abort = 0;
    int b_start, b_sent, b_hsent, b_disc, b_abt, b_abort;

    assign ctl  = {transmit_en, bmc_en, wait_en};
    assign outs = {transmit_en, bmc_en, wait_en, tx_start, tx_kind, tx_abort,
                   txmsgsent, hrstsent, txmsgdisc, txmsgabt, tx_busy};

    apb_ucpd_tx_sched #(.WDOG_W(4)) dut (
        .ic_clk(ic_clk), .ic_rst(ic_rst), .ucpd_en(ucpd_en),
        .txsend_req(txsend_req), .txhrst_req(txhrst_req), .txmode(txmode),
        .rx_busy(rx_busy), .transwin_en(transwin_en), .ifrgap_en(ifrgap_en),
        .hbit_clk_red(hbit_clk_red), .tx_eop_cmplt(tx_eop_cmplt),
        .tx_sop_rst_cmplt(tx_sop_rst_cmplt), .transmit_en(transmit_en),
        .bmc_en(bmc_en), .wait_en(wait_en), .tx_start(tx_start), .tx_kind(tx_kind),
        .tx_abort(tx_abort), .txmsgsent(txmsgsent), .hrstsent(hrstsent),
        .txmsgdisc(txmsgdisc), .txmsgabt(txmsgabt), .tx_busy(tx_busy)
    );

    always #5 ic_clk = ~ic_clk;

    // Pulse counters sampled on the falling edge, away from output updates
    always @(negedge ic_clk) begin
        n_start += int'(tx_start);
        n_sent  += int'(txmsgsent);
        n_hsent += int'(hrstsent);
        n_disc  += int'(txmsgdisc);
        n_abt   += int'(txmsgabt);
        n_abort += int'(tx_abort);
    end

    task automatic tick;
        @(posedge ic_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap;
        b_start = n_start; b_sent = n_sent; b_hsent = n_hsent;
        b_disc = n_disc; b_abt = n_abt; b_abort = n_abort;
    endtask

    task automatic send(input logic [1:0] mode);
        txsend_req = 1'b1;
        txmode = mode;
        tick;
        txsend_req = 1'b0;
        tick;
    endtask

    task automatic pulse_win;
        transwin_en = 1'b1;
        tick;
        transwin_en = 1'b0;
    endtask

    task automatic pulse_gap;
        ifrgap_en = 1'b1;
        tick;
        ifrgap_en = 1'b0;
    endtask

    task automatic pulse_eop;
        tx_eop_cmplt = 1'b1;
        tick;
        tx_eop_cmplt = 1'b0;
    endtask

    task automatic pulse_sop;
        tx_sop_rst_cmplt = 1'b1;
        tick;
        tx_sop_rst_cmplt = 1'b0;
    endtask

    initial begin
        ic_rst = 1'b1; ucpd_en = 1'b0; txsend_req = 1'b0; txhrst_req = 1'b0;
        txmode = 2'd0; rx_busy = 1'b0; transwin_en = 1'b0; ifrgap_en = 1'b0;
        hbit_clk_red = 1'b0; tx_eop_cmplt = 1'b0; tx_sop_rst_cmplt = 1'b0;
        tick;
        tick;
        chk("reset_outs", 32'(outs), 0);
        ic_rst = 1'b0;
        ucpd_en = 1'b1;
        tick;
        chk("idle_outs", 32'(outs), 0);

        // normal message
        snap;
        txsend_req = 1'b1; txmode = 2'd0;
        tick;
        txsend_req = 1'b0;
        chk("t1_latch_no_tx", 32'(transmit_en), 0);
        tick;
        chk("t1_start_ctl", 32'(ctl), 3'b100);
        chk("t1_kind", 32'(tx_kind), 0);
        chk("t1_busy", 32'(tx_busy), 1);
        repeat (3) tick;
        chk("t1_wait_win", 32'(ctl), 3'b100);
        pulse_win;
        chk("t1_tx_start", 32'(tx_start), 1);
        chk("t1_bmc_ctl", 32'(ctl), 3'b110);
        hbit_clk_red = 1'b1;
        pulse_sop;
        hbit_clk_red = 1'b0;
        chk("t1_sop_ignored", 32'(ctl), 3'b110);
        chk("t1_start_pulse", 32'(tx_start), 0);
        repeat (38) tick;
        pulse_eop;
        chk("t1_gap_ctl", 32'(ctl), 3'b101);
        repeat (9) tick;
        chk("t1_gap_hold", 32'(ctl), 3'b101);
        pulse_gap;
        chk("t1_sent", 32'(txmsgsent), 1);
        chk("t1_ctl_off", 32'(ctl), 0);
        chk("t1_busy_off", 32'(tx_busy), 0);
        tick;
        chk("t1_sent_pulse", 32'(txmsgsent), 0);
        chk("t1_n_start", 32'(n_start - b_start), 1);
        chk("t1_n_sent", 32'(n_sent - b_sent), 1);

        // discard on busy receiver
        snap;
        rx_busy = 1'b1;
        txsend_req = 1'b1;
        tick;
        txsend_req = 1'b0;
        chk("t2_no_disc_yet", 32'(txmsgdisc), 0);
        tick;
        chk("t2_disc", 32'(txmsgdisc), 1);
        chk("t2_no_tx", 32'(ctl), 0);
        rx_busy = 1'b0;
        tick;
        chk("t2_disc_pulse", 32'(txmsgdisc), 0);
        chk("t2_idle", 32'({tx_busy, ctl}), 0);
        chk("t2_n_disc", 32'(n_disc - b_disc), 1);

        // simultaneous requests: hard reset first, then message (reserved mode maps to 0)
        snap;
        txsend_req = 1'b1; txhrst_req = 1'b1; txmode = 2'd3;
        tick;
        txsend_req = 1'b0; txhrst_req = 1'b0;
        tick;
        chk("t3_hrst_kind", 32'(tx_kind), 3);
        chk("t3_hrst_ctl", 32'(ctl), 3'b100);
        pulse_win;
        pulse_eop;
        chk("t3_eop_ignored", 32'(ctl), 3'b110);
        pulse_sop;
        chk("t3_gap", 32'(ctl), 3'b101);
        pulse_gap;
        chk("t3_hrstsent", 32'({hrstsent, txmsgsent}), 2'b10);
        chk("t3_ctl_off", 32'(ctl), 0);
        tick;
        chk("t3_msg_ctl", 32'(ctl), 3'b100);
        chk("t3_msg_kind", 32'(tx_kind), 0);
        pulse_win;
        pulse_eop;
        pulse_gap;
        chk("t3_msgsent", 32'({hrstsent, txmsgsent}), 2'b01);
        tick;
        chk("t3_n_sent", 32'(n_sent - b_sent), 1);
        chk("t3_n_hsent", 32'(n_hsent - b_hsent), 1);

        // hard reset aborts a BIST frame on the next half-bit strobe
        snap;
        send(2'd2);
        chk("t4_kind", 32'(tx_kind), 2);
        pulse_win;
        txhrst_req = 1'b1; hbit_clk_red = 1'b1;
        tick;
        txhrst_req = 1'b0; hbit_clk_red = 1'b0;
        chk("t4_no_abort_early", 32'(tx_abort), 0);
        tick;
        chk("t4_wait_hbit", 32'(ctl), 3'b110);
        hbit_clk_red = 1'b1;
        tick;
        hbit_clk_red = 1'b0;
        chk("t4_abort", 32'({tx_abort, txmsgabt}), 2'b11);
        chk("t4_abort_gap", 32'(ctl), 3'b101);
        tick;
        chk("t4_abort_pulse", 32'({tx_abort, txmsgabt}), 0);
        pulse_gap;
        chk("t4_no_status", 32'({txmsgsent, hrstsent}), 0);
        chk("t4_ctl_off", 32'(ctl), 0);
        tick;
        chk("t4_hrst_kind", 32'(tx_kind), 3);
        chk("t4_hrst_ctl", 32'(ctl), 3'b100);
        pulse_win;
        pulse_sop;
        pulse_gap;
        chk("t4_hrstsent", 32'(hrstsent), 1);
        tick;
        chk("t4_n_sent", 32'(n_sent - b_sent), 0);
        chk("t4_n_hsent", 32'(n_hsent - b_hsent), 1);
        chk("t4_n_abt", 32'(n_abt - b_abt), 1);

        // completion in the same cycle as the abort condition wins
        snap;
        send(2'd0);
        pulse_win;
        txhrst_req = 1'b1;
        tick;
        txhrst_req = 1'b0;
        hbit_clk_red = 1'b1;
        pulse_eop;
        hbit_clk_red = 1'b0;
        chk("t5_no_abt", 32'({tx_abort, txmsgabt}), 0);
        chk("t5_gap", 32'(ctl), 3'b101);
        pulse_gap;
        chk("t5_msgsent", 32'(txmsgsent), 1);
        tick;
        chk("t5_hrst_kind", 32'(tx_kind), 3);
        pulse_win;
        pulse_sop;
        pulse_gap;
        chk("t5_hrstsent", 32'(hrstsent), 1);
        tick;
        chk("t5_n_abt", 32'(n_abt - b_abt), 0);

        // disable mid-BMC of a cable reset
        send(2'd1);
        chk("t6_kind", 32'(tx_kind), 1);
        pulse_win;
        pulse_eop;
        chk("t6_eop_ignored", 32'(ctl), 3'b110);
        snap;
        ucpd_en = 1'b0; txhrst_req = 1'b1;
        tick;
        txhrst_req = 1'b0;
        chk("t6_abort", 32'(tx_abort), 1);
        chk("t6_ctl_off", 32'({tx_busy, ctl}), 0);
        chk("t6_no_status", 32'({txmsgsent, hrstsent, txmsgdisc, txmsgabt}), 0);
        tick;
        ucpd_en = 1'b1;
        chk("t6_abort_pulse", 32'(tx_abort), 0);
        tick;
        tick;
        chk("t6_nothing_pending", 32'({tx_busy, ctl}), 0);
        chk("t6_n_status", 32'((n_sent - b_sent) + (n_hsent - b_hsent) + (n_disc - b_disc) + (n_abt - b_abt)), 0);
        chk("t6_n_abort", 32'(n_abort - b_abort), 1);

`ifdef UCPD_TX_WDOG_EN
        // watchdog expiry after 15 START cycles without a transition window
        snap;
        send(2'd0);
        repeat (14) tick;
        chk("t7_still_start", 32'({txmsgdisc, ctl}), 4'b0100);
        tick;
        chk("t7_disc", 32'(txmsgdisc), 1);
        chk("t7_tx_off", 32'(ctl), 0);
        chk("t7_busy_err", 32'(tx_busy), 1);
        tick;
        chk("t7_idle", 32'({tx_busy, txmsgdisc}), 0);
        chk("t7_n_start", 32'(n_start - b_start), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
